// File: rtl/bmain_line_fill.sv
// bmain_line_fill: read-burst initiator on the bmain bus.
// Takes a 16-byte line-fill request and issues one read command. It then gathers
// four 32-bit beats into a 128-bit line and returns that line with an error flag.
// Optional build macro: BMAIN_FILL_TIMEOUT_EN adds a no-progress watchdog of
// TIMEOUT_W bits. When it expires, the fill ends with resp_error set and no error
// acknowledge. Without the macro the block waits for the target indefinitely.

module bmain_line_fill #(
    parameter int TIMEOUT_W = 8
) (
    input  logic          clk_core,
    input  logic          reset_n,
    // line-fill request from the cache
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [27:4]   req_addr,
    // filled line back to the cache
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [127:0]  resp_data,
    output logic          resp_error,
    // bmain command channel
    output logic          fill_cvalid,
    input  logic          bmain_cready,
    output logic          fill_cmd,
    output logic [27:2]   fill_addr,
    // bmain read-data channel
    input  logic          bmain_rvalid,
    output logic          fill_rready,
    input  logic          bmain_rlast,
    input  logic [31:0]   bmain_rdata,
    // bmain error signalling
    input  logic          bmain_error,
    output logic          fill_eack
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_ERR,
        ST_RESP
    } state_t;

    state_t     state;
    logic [1:0] beat;

`ifdef BMAIN_FILL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer;
    logic                 timer_expired;

    // The watchdog trips once the counter has reached all-ones without any progress.
    assign timer_expired = &timer;
`endif

    // Only reads are ever issued.
    assign fill_cmd = 1'b0;

    // Fill sequencer: the state and every registered output are updated together.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            beat        <= 2'd0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            // NOTE: the 128-bit line buffer is reset explicitly. It drives resp_data
            // directly, and resp_data must read as zero out of reset.
            resp_data   <= '0;
            resp_error  <= 1'b0;
            fill_cvalid <= 1'b0;
            fill_addr   <= '0;
            fill_rready <= 1'b0;
            fill_eack   <= 1'b0;
`ifdef BMAIN_FILL_TIMEOUT_EN
            timer       <= '0;
`endif
        end else begin
            // NOTE: every sequential assignment here is non-blocking. That lets this
            // default be overridden by the state branches below without races.
            fill_eack <= 1'b0;

            case (state)
                ST_IDLE: begin
                    // A stray bus error while no fill is in progress is only acknowledged.
                    fill_eack <= bmain_error;
                    if (req_valid) begin
                        fill_addr   <= {req_addr, 2'b00};
                        resp_data   <= '0;
                        resp_error  <= 1'b0;
                        beat        <= 2'd0;
                        req_ready   <= 1'b0;
                        fill_cvalid <= 1'b1;
                        state       <= ST_CMD;
`ifdef BMAIN_FILL_TIMEOUT_EN
                        timer       <= '0;
`endif
                    end
                end

                ST_CMD: begin
                    if (bmain_error) begin
                        fill_cvalid <= 1'b0;
                        fill_eack   <= 1'b1;
                        resp_error  <= 1'b1;
                        state       <= ST_ERR;
                    end else if (bmain_cready) begin
                        fill_cvalid <= 1'b0;
                        fill_rready <= 1'b1;
                        state       <= ST_DATA;
`ifdef BMAIN_FILL_TIMEOUT_EN
                        timer       <= '0;
                    end else if (timer_expired) begin
                        fill_cvalid <= 1'b0;
                        resp_error  <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer       <= timer + 1'b1;
`endif
                    end
                end

                ST_DATA: begin
                    if (bmain_error) begin
                        fill_rready <= 1'b0;
                        fill_eack   <= 1'b1;
                        resp_error  <= 1'b1;
                        state       <= ST_ERR;
                    end else if (bmain_rvalid) begin
                        resp_data[32*beat +: 32] <= bmain_rdata;
                        beat                     <= beat + 2'd1;
`ifdef BMAIN_FILL_TIMEOUT_EN
                        timer                    <= '0;
`endif
                        // The burst ends on the fourth beat or on an early rlast.
                        // A well-formed burst has rlast on the fourth beat and nowhere else.
                        if (beat == 2'd3 || bmain_rlast) begin
                            fill_rready <= 1'b0;
                            resp_valid  <= 1'b1;
                            resp_error  <= !(beat == 2'd3 && bmain_rlast);
                            state       <= ST_RESP;
                        end
`ifdef BMAIN_FILL_TIMEOUT_EN
                    end else if (timer_expired) begin
                        fill_rready <= 1'b0;
                        resp_error  <= 1'b1;
                        resp_valid  <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer       <= timer + 1'b1;
`endif
                    end
                end

                ST_ERR: begin
                    // The acknowledge pulse ends here through the default above.
                    resp_valid <= 1'b1;
                    state      <= ST_RESP;
                end

                ST_RESP: begin
                    fill_eack <= bmain_error;
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    fill_cvalid <= 1'b0;
                    fill_rready <= 1'b0;
                    resp_valid  <= 1'b0;
                    req_ready   <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
